piano_keypad_poly: RTL
======================

Name: piano_keypad_poly

Overview:
- Polyphonic successor of the single-note keypad decoder: converts keypad press/release events into VOICES independent note channels for the downstream tone generators.
- Each channel outputs note (rest=0, C=1 … B=12), octave and gate.
- Shared octave register is stepped by dedicated up/down keys and clamped to a parametrised range.
- Voice allocation: lowest free voice first; round-robin stealing when all voices are busy.

Parameters:
- VOICES, 4, number of output note channels (1..8).
- KEY_W, 5, keycode width.
- OCT_MIN, 0, lowest octave value.
- OCT_MAX, 9, highest octave value.
- OCT_INIT, 4, octave value after reset.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- key_valid  in  1  one-cycle strobe: a key event is present.
- key_press  in  1  qualifies key_valid: 1 = press, 0 = release.
- keycode  in  KEY_W  key index of the event.
- all_off  in  1  release all voices (panic).
- octave_cur  out  4  current shared octave.
- note  out  4*VOICES  per-voice note, voice i at bits [4i+3:4i].
- octave  out  4*VOICES  per-voice octave latched at press time.
- gate  out  VOICES  per-voice key-held flag.
- steal  out  1  one-cycle pulse when a press evicted a held voice.

Behaviour:
- Reset (rst_n=0 at a clk edge): note=0, octave=OCT_INIT, gate=0 for all voices; octave_cur=OCT_INIT; steal_ptr=0; steal=0.
- Every event is accepted; there is no back-pressure.
- Outputs update on the clk edge that samples key_valid=1 (1-cycle latency). steal is registered the same way.
- Key map (package constants):
  - 4=C, 8=C#, 5=D, 9=D#, 6=E, 7=F, 11=F#, 12=G, 16=G#, 13=A, 17=A#, 14=B.
  - 15 = octave up, 19 = octave down.
  - All other codes are ignored (no state change).
- Octave keys:
  - Act on press only: octave_cur ±1, saturating at OCT_MAX / OCT_MIN.
  - Releases of octave keys are ignored.
  - Held voices keep their latched octave when octave_cur changes.
- Note press, code maps to note n; first matching rule applies:
  - (a) A gated voice already holds n: retrigger it. gate stays 1, octave := octave_cur, no other voice changes.
  - (b) Otherwise, if any voice is ungated: the lowest-index ungated voice gets note := n, octave := octave_cur, gate := 1.
  - (c) Otherwise (all voices gated): voice steal_ptr is overwritten as in (b), steal pulses 1, steal_ptr := (steal_ptr+1) mod VOICES.
- Note release, code maps to note n:
  - The gated voice holding n gets gate := 0 and note := 0; its octave register is retained.
  - If no gated voice holds n, nothing changes.
- Invariant: at most one gated voice holds any given note value.
- all_off=1: all gates := 0 and all notes := 0 that cycle. It has priority over a simultaneous key event, which is dropped. steal_ptr is unchanged.
- Reset mid-operation overrides everything, including all_off and events in the same cycle.
- steal_ptr advances only on a steal. It is never reset by releases.
- Width rule: octave arithmetic is done in 5 bits so the saturation compare cannot wrap at 0 or 15.

Decomposition:
- Package piano_pkg:
  - Note constants REST, C..B (4-bit).
  - Keycode constants KEY_C..KEY_B, KEY_OCT_UP, KEY_OCT_DN.
  - Function keycode_to_note returning {valid, note[3:0]}.
- Sub-module voice_alloc: combinational search producing match_idx/match_hit and free_idx/free_any from the gate and note vectors.
- The top level holds the registers, octave logic and steal pointer.

Test Plan:
- Reset, then press 4 → voice0 = {note 1, octave 4, gate 1}; octave_cur=4; steal=0.
- Press 4, 5, 6, 7, then 12 (VOICES=4) → voices 0..3 hold notes 1,3,5,6; press 12 steals voice0 (note 8), steal pulses once; next press 13 steals voice1 (note 10).
- Press 15 six times → octave_cur 5,6,7,8,9,9 (saturates). Then press 19 ten times → saturates at 0. Release of 15 or 19 causes no change.
- Press 4 at octave 4, press 15, press 4 again → still only voice0 gated, note 1, octave 5. Release 4 → voice0 gate=0, note=0, octave=5.
- Hold 4 voices, assert all_off together with a press of 13 → all gates 0, notes 0, press dropped, steal=0. Unmapped keycode 20 → no change.
- Assert rst_n=0 while voices are held and all_off=1 → next cycle all outputs at reset values, octave_cur=4, steal_ptr=0.

Source files
------------

// File: rtl/piano_keypad_poly_pkg.sv
// Shared note/keycode encoding for the polyphonic keypad decoder.
// Note values: rest=0, C=1 .. B=12; keycodes map a keypad matrix index to a note.
package piano_pkg;

  localparam int IDX_W = 3;

  localparam logic [3:0] REST     = 4'd0;
  localparam logic [3:0] NOTE_C   = 4'd1;
  localparam logic [3:0] NOTE_CS  = 4'd2;
  localparam logic [3:0] NOTE_D   = 4'd3;
  localparam logic [3:0] NOTE_DS  = 4'd4;
  localparam logic [3:0] NOTE_E   = 4'd5;
  localparam logic [3:0] NOTE_F   = 4'd6;
  localparam logic [3:0] NOTE_FS  = 4'd7;
  localparam logic [3:0] NOTE_G   = 4'd8;
  localparam logic [3:0] NOTE_GS  = 4'd9;
  localparam logic [3:0] NOTE_A   = 4'd10;
  localparam logic [3:0] NOTE_AS  = 4'd11;
  localparam logic [3:0] NOTE_B   = 4'd12;

  localparam logic [15:0] KEY_C      = 16'd4;
  localparam logic [15:0] KEY_CS     = 16'd8;
  localparam logic [15:0] KEY_D      = 16'd5;
  localparam logic [15:0] KEY_DS     = 16'd9;
  localparam logic [15:0] KEY_E      = 16'd6;
  localparam logic [15:0] KEY_F      = 16'd7;
  localparam logic [15:0] KEY_FS     = 16'd11;
  localparam logic [15:0] KEY_G      = 16'd12;
  localparam logic [15:0] KEY_GS     = 16'd16;
  localparam logic [15:0] KEY_A      = 16'd13;
  localparam logic [15:0] KEY_AS     = 16'd17;
  localparam logic [15:0] KEY_B      = 16'd14;
  localparam logic [15:0] KEY_OCT_UP = 16'd15;
  localparam logic [15:0] KEY_OCT_DN = 16'd19;

  // Returns {valid, note}; valid=0 for octave keys and unmapped codes.
  function automatic logic [4:0] keycode_to_note(input logic [15:0] code);
    case (code)
      KEY_C:   return {1'b1, NOTE_C};
      KEY_CS:  return {1'b1, NOTE_CS};
      KEY_D:   return {1'b1, NOTE_D};
      KEY_DS:  return {1'b1, NOTE_DS};
      KEY_E:   return {1'b1, NOTE_E};
      KEY_F:   return {1'b1, NOTE_F};
      KEY_FS:  return {1'b1, NOTE_FS};
      KEY_G:   return {1'b1, NOTE_G};
      KEY_GS:  return {1'b1, NOTE_GS};
      KEY_A:   return {1'b1, NOTE_A};
      KEY_AS:  return {1'b1, NOTE_AS};
      KEY_B:   return {1'b1, NOTE_B};
      default: return {1'b0, REST};
    endcase
  endfunction

endpackage

// File: rtl/piano_keypad_poly_voice_alloc.sv
// Combinational voice search: gated voice holding target note, and lowest ungated voice.
// Zero latency, no flow control; lowest index wins both searches.
module voice_alloc
  import piano_pkg::*;
#(
  parameter int VOICES = 4
) (
  input  logic [VOICES-1:0]   gate,
  input  logic [4*VOICES-1:0] note,
  input  logic [3:0]          target,
  output logic                match_hit,
  output logic [IDX_W-1:0]    match_idx,
  output logic                free_any,
  output logic [IDX_W-1:0]    free_idx
);

  always_comb begin
    match_hit = 1'b0;
    match_idx = '0;
    free_any  = 1'b0;
    free_idx  = '0;
    // Scan downwards so the last assignment is the lowest index.
    for (int i = VOICES - 1; i >= 0; i--) begin
      if (gate[i] && (note[4*i +: 4] == target)) begin
        match_hit = 1'b1;
        match_idx = IDX_W'(i);
      end
      if (!gate[i]) begin
        free_any = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/piano_keypad_poly.sv
// Polyphonic keypad decoder: key events -> VOICES note/octave/gate channels, shared octave.
// Outputs registered one cycle after the event; every event is accepted, no back-pressure.
module piano_keypad_poly
  import piano_pkg::*;
#(
  parameter int VOICES   = 4,
  parameter int KEY_W    = 5,
  parameter int OCT_MIN  = 0,
  parameter int OCT_MAX  = 9,
  parameter int OCT_INIT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                key_valid,
  input  logic                key_press,
  input  logic [KEY_W-1:0]    keycode,
  input  logic                all_off,
  output logic [3:0]          octave_cur,
  output logic [4*VOICES-1:0] note,
  output logic [4*VOICES-1:0] octave,
  output logic [VOICES-1:0]   gate,
  output logic                steal
);

  logic [4*VOICES-1:0] note_q, note_d;
  logic [4*VOICES-1:0] octave_q, octave_d;
  logic [VOICES-1:0]   gate_q, gate_d;
  logic [3:0]          octave_cur_q, octave_cur_d;
  logic [IDX_W-1:0]    steal_ptr_q, steal_ptr_d;
  logic                steal_q, steal_d;

  logic [15:0]      key_ext;
  logic [4:0]       key_dec;
  logic             key_is_note;
  logic [3:0]       key_note;
  logic             match_hit, free_any;
  logic [IDX_W-1:0] match_idx, free_idx, tgt_idx;
  logic [4:0]       oct_up;

  assign key_ext     = 16'(keycode);
  assign key_dec     = keycode_to_note(key_ext);
  assign key_is_note = key_dec[4];
  assign key_note    = key_dec[3:0];
  assign oct_up      = {1'b0, octave_cur_q} + 5'd1;

  voice_alloc #(.VOICES(VOICES)) u_alloc (
    .gate      (gate_q),
    .note      (note_q),
    .target    (key_note),
    .match_hit (match_hit),
    .match_idx (match_idx),
    .free_any  (free_any),
    .free_idx  (free_idx)
  );

  always_comb begin
    note_d       = note_q;
    octave_d     = octave_q;
    gate_d       = gate_q;
    octave_cur_d = octave_cur_q;
    steal_ptr_d  = steal_ptr_q;
    steal_d      = 1'b0;
    tgt_idx      = match_hit ? match_idx : (free_any ? free_idx : steal_ptr_q);

    if (all_off) begin
      gate_d = '0;
      note_d = '0;
    end else if (key_valid) begin
      if (key_ext == KEY_OCT_UP) begin
        if (key_press && (oct_up <= 5'(OCT_MAX))) octave_cur_d = oct_up[3:0];
      end else if (key_ext == KEY_OCT_DN) begin
        if (key_press && ({1'b0, octave_cur_q} > 5'(OCT_MIN))) octave_cur_d = octave_cur_q - 4'd1;
      end else if (key_is_note && key_press) begin
        for (int i = 0; i < VOICES; i++) begin
          if (IDX_W'(i) == tgt_idx) begin
            note_d[4*i +: 4]   = key_note;
            octave_d[4*i +: 4] = octave_cur_q;
            gate_d[i]          = 1'b1;
          end
        end
        if (!match_hit && !free_any) begin
          steal_d     = 1'b1;
          steal_ptr_d = (steal_ptr_q == IDX_W'(VOICES - 1)) ? '0 : steal_ptr_q + 1'b1;
        end
      end else if (key_is_note && match_hit) begin
        // Release keeps the voice's octave so a decaying tone stays in pitch.
        for (int i = 0; i < VOICES; i++) begin
          if (IDX_W'(i) == match_idx) begin
            note_d[4*i +: 4] = REST;
            gate_d[i]        = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      note_q       <= '0;
      octave_q     <= {VOICES{4'(OCT_INIT)}};
      gate_q       <= '0;
      octave_cur_q <= 4'(OCT_INIT);
      steal_ptr_q  <= '0;
      steal_q      <= 1'b0;
    end else begin
      note_q       <= note_d;
      octave_q     <= octave_d;
      gate_q       <= gate_d;
      octave_cur_q <= octave_cur_d;
      steal_ptr_q  <= steal_ptr_d;
      steal_q      <= steal_d;
    end
  end

  assign octave_cur = octave_cur_q;
  assign note       = note_q;
  assign octave     = octave_q;
  assign gate       = gate_q;
  assign steal      = steal_q;

endmodule
